// File: rtl/bsg_link_ddr_pkg.sv
// Shared constants and helpers for the DDR link: beat sizing, channel ordering
// and the credit token type.
package bsg_link_ddr_pkg;

  // Channel 0 occupies the least significant slice of every reassembled beat.
  localparam bit channel0_lsb_c = 1'b1;

  localparam int default_num_channels_c = 2;
  typedef logic [default_num_channels_c-1:0] token_t;

  function automatic int beat_bits_f(input int num_channels, input int channel_width);
    return num_channels * 2 * channel_width;
  endfunction

  function automatic int beats_per_word_f(input int width, input int beat_bits);
    return width / beat_bits;
  endfunction

endpackage

// File: rtl/bsg_link_ddr_downstream_rx_fifo.sv
// Credit-protected receive FIFO: registered storage, wrapping pointers plus a
// separate full flag. A push into a full FIFO is taken only if a pop frees a slot.
module bsg_link_ddr_downstream_rx_fifo #(
  parameter int width_p = 64,
  parameter int els_p   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic                full_r;
  logic [width_p-1:0]  mem_r [els_p];
  logic                push, pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign v_o    = full_r | (wptr_r != rptr_r);
  assign full_o = full_r;
  assign pop    = yumi_i & v_o;
  assign push   = v_i & (~full_r | pop);
  // Head is masked while empty so the output reads zero out of reset.
  assign data_o = v_o ? mem_r[rptr_r] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= '0;
      rptr_r <= '0;
      full_r <= 1'b0;
    end else begin
      if (push) wptr_r <= ptr_inc(wptr_r);
      if (pop)  rptr_r <= ptr_inc(rptr_r);
      if (push & ~pop)      full_r <= (ptr_inc(wptr_r) == rptr_r);
      else if (pop & ~push) full_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_link_ddr_downstream_rx.sv
// DDR link receive side: reassembles lock-stepped channel beats into core words,
// buffers them, and returns credits upstream as decimated toggle tokens.
module bsg_link_ddr_downstream_rx
  import bsg_link_ddr_pkg::*;
#(
  parameter int width_p                = 64,
  parameter int num_channels_p         = 2,
  parameter int channel_width_p        = 8,
  parameter int fifo_els_p             = 8,
  parameter int lg_credit_decimation_p = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [num_channels_p-1:0]               io_valid_i,
  input  logic [num_channels_p*2*channel_width_p-1:0] io_data_i,
  output logic                                    core_valid_o,
  output logic [width_p-1:0]                      core_data_o,
  input  logic                                    core_yumi_i,
  output logic [num_channels_p-1:0]               token_o,
  output logic                                    error_o
);

  localparam int beat_bits_lp = beat_bits_f(num_channels_p, channel_width_p);
  localparam int bpw_lp       = beats_per_word_f(width_p, beat_bits_lp);
  localparam int cnt_w_lp     = (bpw_lp > 1) ? $clog2(bpw_lp) : 1;
  localparam int dec_w_lp     = (lg_credit_decimation_p > 0) ? lg_credit_decimation_p : 1;
  localparam int slice_lp     = 2 * channel_width_p;

  if ((width_p % beat_bits_lp) != 0 || bpw_lp < 1) begin : g_bad_width
    $error("width_p must be a whole multiple of the io beat width");
  end

  logic [beat_bits_lp-1:0] beat;
  logic [width_p-1:0]      asm_p0, word_p0;
  logic [cnt_w_lp-1:0]     beat_cnt_p0;
  logic [dec_w_lp-1:0]     dec_cnt;
  logic                    beat_ok, partial, last_beat, push, pop, full, drop;

  always_comb begin
    beat = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      beat[c*slice_lp +: slice_lp] =
        io_data_i[(channel0_lsb_c ? c : num_channels_p-1-c)*slice_lp +: slice_lp];
    end
  end

  assign beat_ok   = &io_valid_i;
  assign partial   = (|io_valid_i) & ~beat_ok;
  assign last_beat = (beat_cnt_p0 == cnt_w_lp'(bpw_lp - 1));
  assign push      = beat_ok & last_beat;

  // The final beat joins the buffered beats on its way into the FIFO.
  always_comb begin
    word_p0 = asm_p0;
    word_p0[beat_cnt_p0*beat_bits_lp +: beat_bits_lp] = beat;
  end

  // Stage p0: beat assembly
  always_ff @(posedge clk) begin
    if (beat_ok) asm_p0 <= word_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          beat_cnt_p0 <= '0;
    else if (beat_ok) beat_cnt_p0 <= last_beat ? '0 : beat_cnt_p0 + 1'b1;
  end

  // Stage p1: receive FIFO
  bsg_link_ddr_downstream_rx_fifo #(
    .width_p(width_p),
    .els_p  (fifo_els_p)
  ) fifo (
    .clk   (clk),
    .rst   (rst),
    .v_i   (push),
    .data_i(word_p0),
    .yumi_i(core_yumi_i),
    .v_o   (core_valid_o),
    .data_o(core_data_o),
    .full_o(full)
  );

  assign pop  = core_yumi_i & core_valid_o;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 error_o <= 1'b0;
    else if (partial | drop) error_o <= 1'b1;
  end

  // Credits go back as level toggles, one per decimated group of dequeues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
      token_o <= '0;
    end else if (pop) begin
      if (dec_cnt == dec_w_lp'((1 << lg_credit_decimation_p) - 1)) begin
        dec_cnt <= '0;
        token_o <= ~token_o;
      end else begin
        dec_cnt <= dec_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bsg_link_ddr_downstream_rx.sv
// Scoreboard bench for bsg_link_ddr_downstream_rx at default parameters.
module tb_bsg_link_ddr_downstream_rx;
  import bsg_link_ddr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_valid_i;
  logic [31:0] io_data_i;
  logic        core_valid_o;
  logic [63:0] core_data_o;
  logic        core_yumi_i;
  token_t      token_o;
  logic        error_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb [$];
  int          mbeat, mcount, mdec;
  logic [1:0]  mtok;
  logic        merr;
  logic [31:0] mlow;

  bsg_link_ddr_downstream_rx dut (
    .clk         (clk),
    .rst         (rst),
    .io_valid_i  (io_valid_i),
    .io_data_i   (io_data_i),
    .core_valid_o(core_valid_o),
    .core_data_o (core_data_o),
    .core_yumi_i (core_yumi_i),
    .token_o     (token_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // then check outputs at the following negedge.
  task automatic cycle(input logic [1:0] v, input logic [31:0] d, input logic y);
    logic [63:0] exp_word;
    logic        pop, full_before;
    pop = y && (mcount > 0);
    full_before = (mcount == 8);
    if (y) begin
      check_eq("yumi_valid", core_valid_o, 1'b1);
      if (pop) begin
        exp_word = sb.pop_front();
        check_eq("pop_data", core_data_o, exp_word);
      end
    end
    io_valid_i  = v;
    io_data_i   = d;
    core_yumi_i = y;
    @(posedge clk);
    if (pop) begin
      mcount--;
      mdec = (mdec + 1) % 4;
      if (mdec == 0) mtok = ~mtok;
    end
    if (v == 2'b01 || v == 2'b10) merr = 1'b1;
    if (v == 2'b11) begin
      if (mbeat == 0) begin
        mlow  = d;
        mbeat = 1;
      end else begin
        mbeat = 0;
        if (full_before && !pop) merr = 1'b1;
        else begin
          sb.push_back({d, mlow});
          mcount++;
        end
      end
    end
    @(negedge clk);
    check_eq("valid", core_valid_o, (mcount != 0));
    check_eq("token", token_o, mtok);
    check_eq("error", error_o, merr);
  endtask

  task automatic send_word(input logic [63:0] w, input logic y_last);
    cycle(2'b11, w[31:0], 1'b0);
    cycle(2'b11, w[63:32], y_last);
  endtask

  task automatic pop_one();
    cycle(2'b00, $urandom, 1'b1);
  endtask

  // Asserted between clock edges: outputs must clear without a posedge.
  task automatic reset_async();
    rst = 1'b1;
    io_valid_i  = '0;
    io_data_i   = '0;
    core_yumi_i = 1'b0;
    #1;
    check_eq("rst_valid", core_valid_o, 1'b0);
    check_eq("rst_data",  core_data_o,  64'h0);
    check_eq("rst_token", token_o,      2'b00);
    check_eq("rst_error", error_o,      1'b0);
    sb.delete();
    mbeat = 0; mcount = 0; mdec = 0; mtok = 2'b00; merr = 1'b0; mlow = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    io_valid_i = '0; io_data_i = '0; core_yumi_i = 1'b0;
    @(negedge clk);
    reset_async();

    // Basic reassembly and one-cycle latency
    cycle(2'b11, 32'h4433_2211, 1'b0);
    cycle(2'b11, 32'h8877_6655, 1'b0);
    check_eq("basic_valid", core_valid_o, 1'b1);
    check_eq("basic_data",  core_data_o,  64'h8877665544332211);
    pop_one();

    // Fill, push+pop while full, then overflow drop
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0);
    send_word({$urandom, $urandom}, 1'b1);
    check_eq("full_pushpop_err", error_o, 1'b0);
    send_word({$urandom, $urandom}, 1'b0);
    check_eq("overflow_err", error_o, 1'b1);
    for (int i = 0; i < 8; i++) pop_one();
    check_eq("drained_valid", core_valid_o, 1'b0);

    reset_async();

    // Token decimation
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      pop_one();
      check_eq("tok_decim", token_o, (i < 4) ? 2'b00 : ((i < 8) ? 2'b11 : 2'b00));
    end

    // Partial valid mid-word
    cycle(2'b11, 32'hAAAA_0001, 1'b0);
    cycle(2'b01, 32'hDEAD_BEEF, 1'b0);
    check_eq("partial_err", error_o, 1'b1);
    cycle(2'b11, 32'hBBBB_0002, 1'b0);
    check_eq("partial_word", core_data_o, 64'hBBBB0002AAAA0001);
    pop_one();

    // Reset mid-word and mid-decimation
    for (int i = 0; i < 6; i++) send_word({$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 6; i++) pop_one();
    check_eq("pre_rst_token", token_o, 2'b11);
    cycle(2'b11, $urandom, 1'b0);
    reset_async();
    send_word(64'h0123_4567_89AB_CDEF, 1'b0);
    check_eq("post_rst_data", core_data_o, 64'h0123456789ABCDEF);
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      pop_one();
      check_eq("post_rst_tok", token_o, (i < 4) ? 2'b00 : 2'b11);
    end
    cycle(2'b00, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
